// File: rtl/cnt_reset_sequencer.sv
// Releases the resets of NUM_INST counter instances one at a time, waits for each
// to report start, then waits for every instance to report end before dropping all resets.
//
// state        | meaning
// S_IDLE       | all instances held in reset, waiting for run
// S_RELEASE    | release instance idx on the next edge
// S_WAIT_START | waiting for start_flag[idx], bounded by START_TIMEOUT
// S_GAP        | idle GAP_CYCLES before releasing the next instance
// S_RUN        | all instances running, waiting for every end flag
// S_DONE       | one-cycle completion pulse, resets still released
// S_ERROR      | start or run timeout, all instances held in reset
module cnt_reset_sequencer #(
    parameter int NUM_INST      = 4,
    parameter int GAP_CYCLES    = 8,
    parameter int START_TIMEOUT = 1024,
    parameter int RUN_TIMEOUT   = 0
) (
    input  logic                osc,
    input  logic                reset_n,
    input  logic                run,
    input  logic                abort,
    input  logic [NUM_INST-1:0] start_flag,
    input  logic [NUM_INST-1:0] end_flag,
    output logic [NUM_INST-1:0] inst_reset_n,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [2:0]          err_idx
);

    localparam int C_TMAX_A = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int C_TMAX   = (RUN_TIMEOUT > C_TMAX_A) ? RUN_TIMEOUT : C_TMAX_A;
    localparam int TW       = $clog2(C_TMAX + 1);

    localparam logic [TW-1:0] C_GAP_TC   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] C_START_TC = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] C_RUN_TC   = TW'((RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0);
    localparam logic [2:0]    C_LAST     = 3'(NUM_INST - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_WAIT_START,
        S_GAP,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              r_state;
    logic [2:0]          r_idx;
    logic [TW-1:0]       r_timer;
    logic [NUM_INST-1:0] r_end_seen;
    logic                r_run;
    logic [NUM_INST-1:0] r_inst_reset_n;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [2:0]          r_err_idx;

    state_t              w_state_nxt;
    logic [2:0]          w_idx_nxt;
    logic [TW-1:0]       w_timer_nxt;
    logic [NUM_INST-1:0] w_end_seen_nxt;
    logic [NUM_INST-1:0] w_inst_nxt;
    logic [2:0]          w_err_idx_nxt;
    logic [NUM_INST-1:0] w_end_upd;
    logic [NUM_INST-1:0] w_rel_mask;
    logic                w_start_hit;
    logic [2:0]          w_first_miss;
    logic                w_stopped;

    // End flags only count while that instance is out of reset.
    assign w_end_upd = r_end_seen | (end_flag & r_inst_reset_n);

    always_comb begin
        w_start_hit  = 1'b0;
        w_rel_mask   = '0;
        w_first_miss = 3'd0;
        for (int i = NUM_INST - 1; i >= 0; i--) begin
            if (r_idx == 3'(i)) begin
                w_start_hit   = start_flag[i];
                w_rel_mask[i] = 1'b1;
            end
            if (!w_end_upd[i]) begin
                w_first_miss = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_timer_nxt    = r_timer;
        w_end_seen_nxt = w_end_upd;
        w_inst_nxt     = r_inst_reset_n;
        w_err_idx_nxt  = r_err_idx;
        w_stopped      = 1'b0;

        case (r_state)
            S_IDLE, S_ERROR: begin
                if (r_run) begin
                    w_state_nxt    = S_RELEASE;
                    w_idx_nxt      = 3'd0;
                    w_timer_nxt    = '0;
                    w_end_seen_nxt = '0;
                end
            end
            S_RELEASE: begin
                w_inst_nxt  = r_inst_reset_n | w_rel_mask;
                w_state_nxt = S_WAIT_START;
                w_timer_nxt = '0;
            end
            S_WAIT_START: begin
                if (w_start_hit) begin
                    w_timer_nxt = '0;
                    w_state_nxt = (r_idx == C_LAST) ? S_RUN : S_GAP;
                end else if (r_timer == C_START_TC) begin
                    w_state_nxt   = S_ERROR;
                    w_err_idx_nxt = r_idx;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_GAP: begin
                if (r_timer == C_GAP_TC) begin
                    w_state_nxt = S_RELEASE;
                    w_idx_nxt   = r_idx + 3'd1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_RUN: begin
                if (&w_end_upd) begin
                    w_state_nxt = S_DONE;
                end else if ((RUN_TIMEOUT > 0) && (r_timer == C_RUN_TC)) begin
                    w_state_nxt   = S_ERROR;
                    w_err_idx_nxt = w_first_miss;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (abort) begin
            w_state_nxt = S_IDLE;
        end

        w_stopped = (w_state_nxt == S_IDLE) || (w_state_nxt == S_ERROR);
        if (w_stopped) begin
            w_inst_nxt = '0;
        end
        if (w_state_nxt == S_IDLE) begin
            w_timer_nxt = '0;
        end
        if (w_state_nxt != S_ERROR) begin
            w_err_idx_nxt = 3'd0;
        end
    end

    always_ff @(posedge osc or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_idx          <= 3'd0;
            r_timer        <= '0;
            r_end_seen     <= '0;
            r_run          <= 1'b0;
            r_inst_reset_n <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_err_idx      <= 3'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_timer        <= w_timer_nxt;
            r_end_seen     <= w_end_seen_nxt;
            // run is captured only when the FSM can act on it, and abort always wins.
            r_run          <= run & ~abort & ((r_state == S_IDLE) || (r_state == S_ERROR));
            r_inst_reset_n <= w_inst_nxt;
            r_busy         <= ~w_stopped;
            r_done         <= (w_state_nxt == S_DONE);
            r_error        <= (w_state_nxt == S_ERROR);
            r_err_idx      <= w_err_idx_nxt;
        end
    end

    assign inst_reset_n = r_inst_reset_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign err_idx      = r_err_idx;

endmodule

// File: tb/tb_cnt_reset_sequencer.sv
// Directed bench for cnt_reset_sequencer: normal sequence, start timeout, abort,
// early end flag, async reset mid-run and run timeout with restart.
module tb_cnt_reset_sequencer;

    localparam int N = 4;

    logic         osc = 1'b0;
    logic         reset_n = 1'b0;
    logic         run = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] start_flag = '0;
    logic [N-1:0] end_flag = '0;
    logic [N-1:0] inst_reset_n;
    logic         busy;
    logic         done;
    logic         error;
    logic [2:0]   err_idx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_done = 0;

    cnt_reset_sequencer #(
        .NUM_INST      (N),
        .GAP_CYCLES    (8),
        .START_TIMEOUT (16),
        .RUN_TIMEOUT   (32)
    ) u_dut (
        .osc          (osc),
        .reset_n      (reset_n),
        .run          (run),
        .abort        (abort),
        .start_flag   (start_flag),
        .end_flag     (end_flag),
        .inst_reset_n (inst_reset_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_idx      (err_idx)
    );

    always #5 osc = ~osc;

    always @(posedge osc) cyc <= cyc + 1;
    always @(negedge osc) if (done) n_done <= n_done + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge osc);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_rel(input int i, output int c);
        int k = 0;
        while (!inst_reset_n[i] && k < 60) begin
            tick();
            k++;
        end
        chk($sformatf("rel%0d_seen", i), 32'(inst_reset_n[i]), 32'd1);
        c = cyc;
    endtask

    // Called on the cycle the release is seen; start is sampled 3 edges after release.
    task automatic give_start(input int i);
        tick();
        tick();
        start_flag[i] = 1'b1;
        tick();
        start_flag[i] = 1'b0;
    endtask

    initial begin
        int c;
        int c_prev;
        int d0;

        tick();
        tick();
        chk("rst_inst", 32'(inst_reset_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();

        // normal sequence, all end flags already high
        end_flag = 4'hF;
        d0 = n_done;
        run = 1'b1;
        tick();
        chk("t1_busy_sample", 32'(busy), 32'd0);
        run = 1'b0;
        tick();
        chk("t1_busy_release", 32'(busy), 32'd1);
        chk("t1_inst_before", 32'(inst_reset_n), 32'd0);
        tick();
        chk("t1_rel0_2edges", 32'(inst_reset_n), 32'h1);
        c_prev = cyc;
        start_flag[2] = 1'b1;
        tick();
        start_flag[2] = 1'b0;
        tick();
        start_flag[0] = 1'b1;
        tick();
        start_flag[0] = 1'b0;
        for (int i = 1; i < N; i++) begin
            wait_rel(i, c);
            chk($sformatf("t1_spacing%0d", i), 32'(c - c_prev), 32'd12);
            c_prev = c;
            give_start(i);
        end
        chk("t1_run_nodone", 32'(done), 32'd0);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_inst_done", 32'(inst_reset_n), 32'hF);
        tick();
        chk("t1_done_end", 32'(done), 32'd0);
        chk("t1_inst_idle", 32'(inst_reset_n), 32'd0);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_one_done", 32'(n_done - d0), 32'd1);

        // start timeout on instance 2
        end_flag = '0;
        pulse_run();
        wait_rel(0, c);
        give_start(0);
        wait_rel(1, c);
        give_start(1);
        wait_rel(2, c);
        repeat (15) tick();
        chk("t2_err_early", 32'(error), 32'd0);
        tick();
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_err_idx", 32'(err_idx), 32'd2);
        chk("t2_inst", 32'(inst_reset_n), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t2_err_clr", 32'(error), 32'd0);
        chk("t2_idx_clr", 32'(err_idx), 32'd0);

        // abort during gap with run also high
        d0 = n_done;
        pulse_run();
        wait_rel(0, c);
        give_start(0);
        wait_rel(1, c);
        give_start(1);
        tick();
        tick();
        abort = 1'b1;
        run = 1'b1;
        tick();
        abort = 1'b0;
        run = 1'b0;
        chk("t3_inst", 32'(inst_reset_n), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("t3_no_restart", 32'(inst_reset_n), 32'd0);
        chk("t3_no_done", 32'(n_done - d0), 32'd0);

        // early end on instance 0; end of instance 3 while in reset is ignored
        d0 = n_done;
        pulse_run();
        wait_rel(0, c);
        give_start(0);
        wait_rel(1, c);
        give_start(1);
        wait_rel(2, c);
        end_flag[3] = 1'b1;
        tick();
        end_flag[3] = 1'b0;
        tick();
        start_flag[2] = 1'b1;
        tick();
        start_flag[2] = 1'b0;
        wait_rel(3, c);
        end_flag[0] = 1'b1;
        tick();
        end_flag[0] = 1'b0;
        tick();
        start_flag[3] = 1'b1;
        tick();
        start_flag[3] = 1'b0;
        end_flag = 4'b0110;
        tick();
        tick();
        chk("t4_wait_end3", 32'(done), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        end_flag = 4'b1000;
        tick();
        end_flag = '0;
        chk("t4_done", 32'(done), 32'd1);
        tick();
        chk("t4_inst_idle", 32'(inst_reset_n), 32'd0);
        chk("t4_one_done", 32'(n_done - d0), 32'd1);

        // async reset between edges during run
        d0 = n_done;
        pulse_run();
        for (int i = 0; i < N; i++) begin
            wait_rel(i, c);
            give_start(i);
        end
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_inst", 32'(inst_reset_n), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        pulse_run();
        tick();
        chk("t5_restart_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_restart_idx0", 32'(inst_reset_n), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // run timeout with end of instance 1 missing, then restart from error
        end_flag = 4'b1101;
        pulse_run();
        for (int i = 0; i < N; i++) begin
            wait_rel(i, c);
            give_start(i);
        end
        repeat (31) tick();
        chk("t6_err_early", 32'(error), 32'd0);
        tick();
        chk("t6_error", 32'(error), 32'd1);
        chk("t6_err_idx", 32'(err_idx), 32'd1);
        chk("t6_inst", 32'(inst_reset_n), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        pulse_run();
        chk("t6_err_hold", 32'(error), 32'd1);
        tick();
        chk("t6_err_clr", 32'(error), 32'd0);
        chk("t6_idx_clr", 32'(err_idx), 32'd0);
        tick();
        chk("t6_rerelease0", 32'(inst_reset_n), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        end_flag = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cnt_reset_sequencer.md
CNT_RESET_SEQUENCER -- requirements
Module: cnt_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_INST, default 4: number of counter instances sequenced, range 2..8.
REQ-002 SHALL have parameter GAP_CYCLES, default 8: idle cycles between one instance's start and the next release, minimum 1.
REQ-003 SHALL have parameter START_TIMEOUT, default 1024: maximum cycles in WAIT_START before error, minimum 2.
REQ-004 SHALL have parameter RUN_TIMEOUT, default 0: maximum cycles in RUN before error; 0 disables the check.
REQ-005 SHALL have port osc, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port run, input, 1 bit: start-sequence request, level sampled.
REQ-008 SHALL have port abort, input, 1 bit: terminate any sequence, level sampled.
REQ-009 SHALL have port start_flag, input, NUM_INST bits: per-instance "count started" indication.
REQ-010 SHALL have port end_flag, input, NUM_INST bits: per-instance "count ended" indication.
REQ-011 SHALL have port inst_reset_n, output, NUM_INST bits: registered active-low reset to each counter instance.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE and ERROR.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the sequence completes.
REQ-014 SHALL have port error, output, 1 bit: high while in ERROR.
REQ-015 SHALL have port err_idx, output, 3 bits: index of the instance that timed out; 0 otherwise.

Function
REQ-016 SHALL implement states IDLE, RELEASE, WAIT_START, GAP, RUN, DONE, ERROR, plus a 3-bit index idx, a timer sized for max(GAP_CYCLES, START_TIMEOUT, RUN_TIMEOUT), and sticky register end_seen[NUM_INST].
REQ-017 IDLE: all inst_reset_n=0; run=1 -> RELEASE, idx=0, end_seen cleared.
REQ-018 RELEASE: next edge sets inst_reset_n[idx]=1, where it stays, and enters WAIT_START with timer=0; inst_reset_n[0] rises exactly 2 edges after the edge that samples run in IDLE.
REQ-019 WAIT_START: start_flag[idx]=1 -> GAP if idx<NUM_INST-1, else RUN with timer=0; otherwise increment timer; after START_TIMEOUT cycles without start -> ERROR, err_idx=idx.
REQ-020 GAP: stays exactly GAP_CYCLES cycles, then RELEASE with idx+1.
REQ-021 end_seen[i] SHALL set on any cycle where end_flag[i]=1 and inst_reset_n[i]=1; end_flag of an instance still in reset is ignored.
REQ-022 RUN: end_seen all ones (including bits set during this cycle) -> DONE; if RUN_TIMEOUT>0 and RUN_TIMEOUT cycles elapse first -> ERROR, err_idx = lowest index with end_seen=0.
REQ-023 DONE: done=1 for exactly one cycle, all inst_reset_n driven 0 on the same edge that enters IDLE.
REQ-024 ERROR: all inst_reset_n=0, error=1; run=1 -> RELEASE, idx=0, error and err_idx cleared, end_seen cleared.
REQ-025 abort=1 in any state other than IDLE SHALL enter IDLE on the next edge with all inst_reset_n=0, no done pulse, error cleared.
REQ-026 abort and run both high SHALL resolve to abort.
REQ-027 run while busy SHALL be ignored; run held high after DONE SHALL restart a new sequence from IDLE.
REQ-028 start_flag of instances other than idx SHALL be ignored.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, idx=0, timer=0, end_seen=0, inst_reset_n=0, busy=0, done=0, error=0, err_idx=0, independent of osc.
REQ-031 Reset asserted mid-sequence SHALL abandon it with no done pulse; after release the block waits in IDLE for run.

Verification
REQ-032 Normal run (NUM_INST=4, GAP_CYCLES=8): run pulse; start_flag[i] 3 cycles after each release; end_flag all high -> inst_reset_n rises 0,1,2,3 spaced 3+1+8 edges apart (3 WAIT_START, 1 RELEASE, 8 GAP); one done pulse; then inst_reset_n=4'b0000.
REQ-033 Start timeout (START_TIMEOUT=16): start_flag[2] never asserted -> error=1 exactly 16 cycles after WAIT_START entry for idx 2, err_idx=2, inst_reset_n=0, busy=0.
REQ-034 Abort during GAP after instance 1 started, with run also high -> IDLE next edge, inst_reset_n=0, done never pulses.
REQ-035 Early end: end_flag[0] pulses while instance 3 is in WAIT_START -> recorded; RUN exits to DONE once end_flag[1..3] arrive; done pulses once.
REQ-036 Async reset asserted between edges during RUN -> outputs cleared before the next osc edge; run after release restarts at idx 0.
REQ-037 RUN_TIMEOUT=32, end_flag[1] missing -> ERROR after 32 RUN cycles, err_idx=1; a subsequent run pulse clears error and re-releases instance 0.
